// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan multiplexer.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;
  localparam int unsigned NDIG     = 4;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [0:0] {SCAN, GAP} state_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  // Table lookup.
  always_comb begin
    pattern = HEX_SEG[nibble];
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Four-digit common-anode display scanner with double-buffered value,
// inter-digit blanking gap and optional leading-zero blanking.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame_done
);

  localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] disp_q, disp_d, pend_q, pend_d;
  logic [3:0]  dpd_q, dpd_d, dpp_q, dpp_d;
  logic        pv_q, pv_d;
  logic        commit;

  logic [3:0]  an_d;
  logic [6:0]  seg_d, digit_seg;
  logic        dp_n_d;
  logic [3:0]  nibble;
  logic        blank;

  seg7_hex_decode u_dec (
    .nibble  (nibble),
    .pattern (digit_seg)
  );

  // Next-state: scan/gap sequencing, index advance and buffer commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    disp_d  = disp_q;
    dpd_d   = dpd_q;
    pend_d  = pend_q;
    dpp_d   = dpp_q;
    pv_d    = pv_q;
    commit  = 1'b0;

    unique case (state_q)
      SCAN: begin
        if (tick) begin
          idx_d   = idx_q + 2'd1;
          state_d = GAP;
          cnt_d   = GAP_INIT;
          commit  = (idx_q == 2'd3);
        end
      end
      GAP: begin
        // Ticks are ignored while blanked.
        if (cnt_q <= 4'd1) begin
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = GAP;
    endcase

    if (commit) begin
      // A load on the wrap tick bypasses the pending buffer.
      if (load) begin
        disp_d = value;
        dpd_d  = dp_in;
      end else if (pv_q) begin
        disp_d = pend_q;
        dpd_d  = dpp_q;
      end
      pv_d = 1'b0;
    end else if (load) begin
      pend_d = value;
      dpp_d  = dp_in;
      pv_d   = 1'b1;
    end
  end

  // Output decode from the next state so an/seg change with the state edge.
  always_comb begin
    nibble = disp_q[{idx_q, 2'b00} +: 4];
    unique case (idx_q)
      2'd3:    blank = blank_lz && (disp_q[15:12] == 4'd0);
      2'd2:    blank = blank_lz && (disp_q[15:8] == 8'd0);
      2'd1:    blank = blank_lz && (disp_q[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase

    an_d   = AN_OFF;
    seg_d  = SEG_BLANK;
    dp_n_d = 1'b1;
    if (state_d == SCAN) begin
      an_d = ~(4'b0001 << idx_q);
      if (!blank) begin
        seg_d  = digit_seg;
        dp_n_d = ~dpd_q[idx_q];
      end
    end
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= GAP;
      cnt_q      <= GAP_INIT;
      idx_q      <= 2'd0;
      disp_q     <= 16'd0;
      dpd_q      <= 4'd0;
      pend_q     <= 16'd0;
      dpp_q      <= 4'd0;
      pv_q       <= 1'b0;
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      dpd_q      <= dpd_d;
      pend_q     <= pend_d;
      dpp_q      <= dpp_d;
      pv_q       <= pv_d;
      an         <= an_d;
      seg        <= seg_d;
      dp_n       <= dp_n_d;
      frame_done <= commit;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux against a countdown-style display model.
module tb_seg7_scan_mux;

  localparam int unsigned G = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic [15:0] value = 16'd0;
  logic [3:0]  dp_in = 4'd0;
  logic        blank_lz = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Model: which digit is lit, how many blank cycles remain, buffers.
  int          m_off;
  int          m_dig;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dpd, m_dpp;
  bit          m_pv, m_fd, m_blz;

  always #5 clk = ~clk;

  seg7_scan_mux #(.GAP_CYCLES(G)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .value      (value),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .load       (load),
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h10; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
    endcase
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [15:0] hi;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (m_off == 0) begin
      e_an = 4'hF;
      e_an[m_dig] = 1'b0;
      hi = m_disp >> (4 * m_dig);
      if (!(m_blz && m_dig != 0 && hi == 16'd0)) begin
        e_seg = hex7(hi[3:0]);
        e_dp  = ~m_dpd[m_dig];
      end
    end
    check("an", {3'b0, an}, {3'b0, e_an});
    check("seg", seg, e_seg);
    check("dp_n", {6'b0, dp_n}, {6'b0, e_dp});
    check("frame_done", {6'b0, frame_done}, {6'b0, m_fd});
  endtask

  // One clock: apply inputs, advance the model at the edge, compare after it.
  task automatic step(input bit t, input bit l, input logic [15:0] v, input logic [3:0] d,
                      input bit r);
    bit lit, wrap;
    tick = t; load = l; value = v; dp_in = d; reset = r;
    @(posedge clk);
    m_blz = blank_lz;
    if (r) begin
      m_off = G; m_dig = 0; m_disp = 0; m_dpd = 0; m_pend = 0; m_dpp = 0;
      m_pv = 0; m_fd = 0;
    end else begin
      lit  = (m_off == 0);
      m_fd = 0;
      wrap = lit && t && (m_dig == 3);
      if (lit && t) begin
        m_dig = (m_dig + 1) % 4;
        m_off = G;
      end else if (!lit) begin
        m_off--;
      end
      if (wrap) begin
        m_fd = 1;
        if (l) begin
          m_disp = v; m_dpd = d;
        end else if (m_pv) begin
          m_disp = m_pend; m_dpd = m_dpp;
        end
        m_pv = 0;
      end else if (l) begin
        m_pend = v; m_dpp = d; m_pv = 1;
      end
    end
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'($urandom), 4'($urandom), 0);
  endtask

  task automatic do_tick();
    step(1, 0, 16'($urandom), 4'($urandom), 0);
    idle(G + 1);
  endtask

  // Tick until digit d is lit, bounded.
  task automatic advance_to(input int d);
    int n;
    n = 0;
    while (!(m_off == 0 && m_dig == d) && n < 60) begin
      step(m_off == 0, 0, 16'($urandom), 4'($urandom), 0);
      n++;
    end
    checks++;
    assert (n < 60) else begin
      errors++;
      $error("FAIL advance_to got=timeout exp=digit%0d", d);
    end
  endtask

  initial begin
    // 1: reset, gap, then digit 0 shows 0.
    step(0, 0, 16'd0, 4'd0, 1);
    step(0, 0, 16'd0, 4'd0, 1);
    idle(G);
    check("rst_an", {3'b0, an}, 7'h0E);
    check("rst_seg", seg, 7'h40);
    idle(3);

    // 2: load 1234, nothing shown until wrap.
    step(0, 1, 16'h1234, 4'b0010, 0);
    for (int i = 0; i < 4; i++) do_tick();
    check("wrap_d0", seg, 7'h19);
    advance_to(1);
    check("wrap_d1", seg, 7'h30);
    advance_to(0);

    // 3: leading-zero blanking.
    blank_lz = 1'b1;
    step(0, 1, 16'h0050, 4'd0, 0);
    for (int i = 0; i < 8; i++) do_tick();
    advance_to(2);
    check("lz_d2", seg, 7'h7F);

    // 4: tick inside the gap is ignored.
    step(1, 0, 16'd0, 4'd0, 0);
    step(1, 0, 16'd0, 4'd0, 0);
    step(1, 0, 16'd0, 4'd0, 0);
    idle(G + 2);
    blank_lz = 1'b0;

    // 5: last load wins; load on the wrap tick bypasses.
    advance_to(0);
    step(0, 1, 16'hAAAA, 4'hF, 0);
    step(0, 1, 16'hBBBB, 4'h0, 0);
    advance_to(3);
    step(1, 0, 16'd0, 4'd0, 0);
    idle(G);
    check("lastwins", seg, 7'h03);
    advance_to(3);
    step(1, 1, 16'hC3C3, 4'h5, 0);
    idle(G);
    check("bypass", seg, 7'h30);

    // 6: reset with a pending load mid-frame.
    advance_to(1);
    step(0, 1, 16'h9999, 4'hF, 0);
    step(0, 0, 16'd0, 4'd0, 1);
    idle(G);
    check("rst2_seg", seg, 7'h40);
    for (int i = 0; i < 4; i++) do_tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) blank_lz = 1'($urandom);
      step($urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0, 16'($urandom),
           4'($urandom), $urandom_range(0, 499) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
